// File: rtl/if_id_buf.sv
// Fetch-to-decode skid buffer: show-ahead circular FIFO of {pc, inst} entries.
// Latency: one cycle from an accepted push to the head when empty; there is no bypass path.
// Backpressure: ready_o comes from registered occupancy only; a full buffer refuses pushes even when a pop is pending.

`ifndef PORT_ADDR_WIDTH
`define PORT_ADDR_WIDTH 32
`endif
`ifndef PORT_WORD_WIDTH
`define PORT_WORD_WIDTH 32
`endif

module if_id_buf #(
    parameter int                          DEPTH    = 2,
    parameter logic [`PORT_WORD_WIDTH-1:0] NOP_INST = 32'h0000_0013
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [`PORT_ADDR_WIDTH-1:0]  if_id_buf_pc_i,
    input  logic [`PORT_WORD_WIDTH-1:0]  if_id_buf_inst_i,
    input  logic                         if_id_buf_valid_i,
    output logic                         if_id_buf_ready_o,
    output logic [`PORT_ADDR_WIDTH-1:0]  if_id_buf_pc_o,
    output logic [`PORT_WORD_WIDTH-1:0]  if_id_buf_inst_o,
    output logic                         if_id_buf_valid_o,
    input  logic                         if_id_buf_ready_i,
    input  logic                         if_id_buf_pipeline_flush_flag,
    output logic [$clog2(DEPTH):0]       if_id_buf_count_o
);

    localparam int               PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);

    typedef struct packed {
        logic [`PORT_ADDR_WIDTH-1:0] pc;
        logic [`PORT_WORD_WIDTH-1:0] inst;
    } entry_t;

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             push;
    logic             pop;
    entry_t           head;

    assign if_id_buf_ready_o = (count < FULL_CNT);
    assign if_id_buf_valid_o = (count != '0);
    assign if_id_buf_count_o = count;

    assign push = if_id_buf_valid_i && if_id_buf_ready_o;
    assign pop  = if_id_buf_valid_o && if_id_buf_ready_i;

    // Storage is never reset; valid_o gates what decode can observe.
    always_ff @(posedge clk) begin
        if (push && !if_id_buf_pipeline_flush_flag) begin
            mem[wr_ptr] <= '{pc: if_id_buf_pc_i, inst: if_id_buf_inst_i};
        end
    end

    // DEPTH is a power of two, so pointer increment wraps DEPTH-1 -> 0 naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (if_id_buf_pipeline_flush_flag) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        head             = mem[rd_ptr];
        if_id_buf_pc_o   = '0;
        if_id_buf_inst_o = NOP_INST;
        if (if_id_buf_valid_o) begin
            if_id_buf_pc_o   = head.pc;
            if_id_buf_inst_o = head.inst;
        end
    end

endmodule

// File: tb/tb_if_id_buf.sv
// Directed bench for if_id_buf: the driver queues each accepted fetch entry, and a monitor checks every consumed head against it.
module tb_if_id_buf;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_i;
    logic [31:0] inst_i;
    logic        valid_i;
    logic        ready_o;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        valid_o;
    logic        ready_i;
    logic        flush;
    logic [1:0]  count_o;

    int   checks = 0;
    int   errors = 0;
    ent_t exp_q[$];
    logic acc;

    if_id_buf #(.DEPTH(2), .NOP_INST(32'h0000_0013)) dut (
        .clk                           (clk),
        .rst_n                         (rst_n),
        .if_id_buf_pc_i                (pc_i),
        .if_id_buf_inst_i              (inst_i),
        .if_id_buf_valid_i             (valid_i),
        .if_id_buf_ready_o             (ready_o),
        .if_id_buf_pc_o                (pc_o),
        .if_id_buf_inst_o              (inst_o),
        .if_id_buf_valid_o             (valid_o),
        .if_id_buf_ready_i             (ready_i),
        .if_id_buf_pipeline_flush_flag (flush),
        .if_id_buf_count_o             (count_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic idle_state(input string tag);
        check({tag, "_valid"}, 64'(valid_o), 64'd0);
        check({tag, "_ready"}, 64'(ready_o), 64'd1);
        check({tag, "_count"}, 64'(count_o), 64'd0);
        check({tag, "_pc"},    64'(pc_o),    64'd0);
        check({tag, "_inst"},  64'(inst_o),  64'(NOP));
    endtask

    // Drive one cycle's inputs just after the edge; sample at the following negedge.
    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                         input logic rdy, input logic fl, output logic accepted);
        @(posedge clk);
        #1;
        valid_i = v;
        pc_i    = pc;
        inst_i  = inst;
        ready_i = rdy;
        flush   = fl;
        @(negedge clk);
        accepted = v && ready_o && !fl;
        if (accepted) exp_q.push_back('{pc: pc, inst: inst});
        if (fl) exp_q.delete();
    endtask

    // Scoreboard monitor: every head consumed by decode must match the oldest queued entry.
    always @(negedge clk) begin
        if (rst_n && valid_o && ready_i && !flush) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_unexpected actual=%h required=none", pc_o);
            end else begin
                ent_t e;
                e = exp_q.pop_front();
                check("pop_pc",   64'(pc_o),   64'(e.pc));
                check("pop_inst", 64'(inst_o), 64'(e.inst));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; valid_i = 1'b0; pc_i = '0; inst_i = '0; ready_i = 1'b0; flush = 1'b0;
        #2;
        idle_state("in_reset");
        #10 rst_n = 1'b1;
        #1;
        idle_state("post_reset");

        // Single entry: one-cycle latency, then empty again.
        drive(1, 32'h100, 32'h0050_0093, 1, 0, acc);
        check("single_acc",     64'(acc),     64'd1);
        check("single_nobyp",   64'(valid_o), 64'd0);
        drive(0, 0, 0, 1, 0, acc);
        check("single_valid",   64'(valid_o), 64'd1);
        check("single_pc",      64'(pc_o),    64'h100);
        check("single_inst",    64'(inst_o),  64'h0050_0093);
        drive(0, 0, 0, 1, 0, acc);
        check("single_empty",   64'(valid_o), 64'd0);
        check("single_nop",     64'(inst_o),  64'(NOP));

        // Stall to full, then release.
        drive(1, 32'h0, 32'hA0, 0, 0, acc);
        check("stall_acc0",     64'(acc),     64'd1);
        drive(1, 32'h4, 32'hA4, 0, 0, acc);
        check("stall_acc1",     64'(acc),     64'd1);
        check("stall_head",     64'(pc_o),    64'h0);
        drive(1, 32'h8, 32'hA8, 0, 0, acc);
        check("stall_full_rdy", 64'(ready_o), 64'd0);
        check("stall_full_cnt", 64'(count_o), 64'd2);
        check("stall_held",     64'(acc),     64'd0);
        check("stall_head2",    64'(pc_o),    64'h0);
        drive(1, 32'h8, 32'hA8, 1, 0, acc);
        check("full_pop_noacc", 64'(acc),     64'd0);
        drive(1, 32'h8, 32'hA8, 1, 0, acc);
        check("release_acc",    64'(acc),     64'd1);
        check("release_cnt",    64'(count_o), 64'd1);
        drive(0, 0, 0, 1, 0, acc);
        check("release_head",   64'(pc_o),    64'h8);
        drive(0, 0, 0, 1, 0, acc);
        check("release_empty",  64'(count_o), 64'd0);

        // Streaming: steady one-in one-out, pointers wrap repeatedly.
        for (int i = 0; i < 10; i++) begin
            drive(1, 32'h1000 + 32'(4 * i), 32'hC000 + 32'(i), 1, 0, acc);
            check("stream_acc", 64'(acc), 64'd1);
            check("stream_cnt", 64'(count_o), (i == 0) ? 64'd0 : 64'd1);
        end
        drive(0, 0, 0, 1, 0, acc);
        check("stream_last",    64'(pc_o),    64'h1024);
        drive(0, 0, 0, 1, 0, acc);
        check("stream_drained", 64'(count_o), 64'd0);

        // Flush with count=2 and a concurrent push.
        drive(1, 32'h500, 32'hB0, 0, 0, acc);
        drive(1, 32'h504, 32'hB4, 0, 0, acc);
        drive(1, 32'h200, 32'hBB, 1, 1, acc);
        check("flush_pre_cnt",  64'(count_o), 64'd2);
        drive(0, 0, 0, 1, 0, acc);
        idle_state("after_flush");
        // Flush with room available: the push must still be dropped.
        drive(1, 32'h510, 32'hB8, 0, 0, acc);
        drive(1, 32'h204, 32'hBC, 0, 1, acc);
        check("flush2_rdy",     64'(ready_o), 64'd1);
        drive(0, 0, 0, 1, 0, acc);
        idle_state("after_flush2");

        // Asynchronous reset mid-cycle with count=2.
        drive(1, 32'h700, 32'hD0, 0, 0, acc);
        drive(1, 32'h704, 32'hD4, 0, 0, acc);
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        check("pre_rst_cnt",    64'(count_o), 64'd2);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid",     64'(valid_o), 64'd0);
        check("arst_count",     64'(count_o), 64'd0);
        exp_q.delete();
        @(negedge clk);
        idle_state("arst_hold");
        rst_n = 1'b1;
        drive(1, 32'h300, 32'hE0, 1, 0, acc);
        check("arst_push_acc",  64'(acc),     64'd1);
        drive(0, 0, 0, 1, 0, acc);
        check("arst_valid2",    64'(valid_o), 64'd1);
        check("arst_pc",        64'(pc_o),    64'h300);

        // Full with simultaneous pop: pop only, push admitted next cycle.
        drive(1, 32'h600, 32'hF0, 0, 0, acc);
        drive(1, 32'h604, 32'hF4, 0, 0, acc);
        drive(1, 32'h608, 32'hF8, 1, 0, acc);
        check("fullpop_rdy",    64'(ready_o), 64'd0);
        check("fullpop_noacc",  64'(acc),     64'd0);
        drive(0, 0, 0, 0, 0, acc);
        check("fullpop_rdy2",   64'(ready_o), 64'd1);
        check("fullpop_cnt",    64'(count_o), 64'd1);
        check("fullpop_head",   64'(pc_o),    64'h604);
        drive(0, 0, 0, 1, 0, acc);
        drive(0, 0, 0, 1, 0, acc);
        check("final_empty",    64'(count_o), 64'd0);
        check("sb_drained",     64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_id_buf.md
IF_ID_BUF -- requirements
Module: if_id_buf

Interface
- REQ-001 SHALL have parameter DEPTH, default 2, number of buffered fetch entries (power of two, 2..8).
- REQ-002 SHALL have parameter NOP_INST, default 32'h0000_0013, instruction presented when no entry is valid (addi x0,x0,0).
- REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
- REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
- REQ-005 SHALL have port if_id_buf_pc_i  input  `PORT_ADDR_WIDTH  PC of fetched instruction.
- REQ-006 SHALL have port if_id_buf_inst_i  input  `PORT_WORD_WIDTH  fetched instruction word.
- REQ-007 SHALL have port if_id_buf_valid_i  input  1  fetch presents an entry this cycle.
- REQ-008 SHALL have port if_id_buf_ready_o  output  1  buffer accepts an entry this cycle.
- REQ-009 SHALL have port if_id_buf_pc_o  output  `PORT_ADDR_WIDTH  PC of head entry, toward decode.
- REQ-010 SHALL have port if_id_buf_inst_o  output  `PORT_WORD_WIDTH  instruction of head entry.
- REQ-011 SHALL have port if_id_buf_valid_o  output  1  head entry valid.
- REQ-012 SHALL have port if_id_buf_ready_i  input  1  decode/id_ex stage consumes head this cycle (low = stall).
- REQ-013 SHALL have port if_id_buf_pipeline_flush_flag  input  1  flush from ctrl; discards all entries.
- REQ-014 SHALL have port if_id_buf_count_o  output  $clog2(DEPTH)+1  number of valid entries.

Function
- REQ-015 SHALL implement a show-ahead circular FIFO of DEPTH entries {pc, inst} with write pointer, read pointer, and occupancy count.
- REQ-016 SHALL push when valid_i && ready_o; pop when valid_o && ready_i.
- REQ-017 SHALL drive ready_o = (count < DEPTH) from registered state only; no combinational path from ready_i to ready_o.
- REQ-018 SHALL drive valid_o = (count != 0).
- REQ-019 SHALL not bypass: an entry pushed in cycle N appears on outputs no earlier than cycle N+1 (latency 1 when empty).
- REQ-020 SHALL drive pc_o/inst_o from the entry at the read pointer when valid_o=1; otherwise pc_o=0 and inst_o=NOP_INST.
- REQ-021 SHALL leave count unchanged on simultaneous push and pop, with both pointers advancing.
- REQ-022 SHALL, when full, deassert ready_o, so a same-cycle pop does not admit a push; the push is admitted in the next cycle.
- REQ-023 SHALL, when empty, ignore ready_i; no pop occurs and count does not underflow.
- REQ-024 SHALL wrap pointers modulo DEPTH, from DEPTH-1 to 0.
- REQ-025 SHALL, on flush_flag=1 at a clock edge, set count, write pointer, and read pointer to 0, and discard any push or pop in that cycle; flush has highest priority.
- REQ-026 SHALL, in the cycle after flush, present valid_o=0, inst_o=NOP_INST, pc_o=0, and ready_o=1.
- REQ-027 SHALL hold buffered entries and outputs stable while ready_i=0 (stall), regardless of further fetch pushes up to full.
- REQ-028 SHALL not write storage when no push occurs; pc and inst are stored together atomically.

Reset
- REQ-029 SHALL, on rst_n=0, asynchronously clear count, write pointer, and read pointer to 0, independent of clk.
- REQ-030 SHALL present, during and after reset: valid_o=0, ready_o=1, count_o=0, pc_o=0, inst_o=NOP_INST; storage contents need not be cleared.
- REQ-031 SHALL discard all in-flight entries on reset asserted mid-operation; the first push after release appears at the head one cycle later.

Verification
- REQ-032 SHALL cover single entry: empty buffer, push pc=0x100, inst=0x00500093, ready_i=1 -> next cycle valid_o=1, pc_o=0x100, inst_o=0x00500093; following cycle valid_o=0, inst_o=0x00000013.
- REQ-033 SHALL cover stall to full: ready_i=0, push pc 0x0, 0x4, 0x8 back-to-back -> first two accepted, ready_o=0 with count_o=2 and the third held by fetch; release ready_i -> pops in order 0x0, 0x4, then 0x8 accepted.
- REQ-034 SHALL cover streaming: valid_i=1 and ready_i=1 continuously for 10 cycles, pc incrementing by 4 -> after 1-cycle fill, one entry per cycle in order, count_o constant at 1, pointers wrap without loss.
- REQ-035 SHALL cover flush with simultaneous push: count=2, flush_flag=1 with valid_i=1 and pc=0x200 -> next cycle count_o=0, valid_o=0, inst_o=0x00000013; 0x200 not stored.
- REQ-036 SHALL cover async reset: rst_n pulled low mid-cycle with count=2 -> valid_o=0 and count_o=0 immediately without a clock edge; after release, push 0x300 -> valid_o=1, pc_o=0x300 next cycle.
- REQ-037 SHALL cover full with simultaneous pop: count=DEPTH, ready_i=1, valid_i=1 -> that cycle pops one and pushes none; next cycle ready_o=1, count_o=DEPTH-1.
